uart_csr_ctrl: RTL and testbench

//  Register/FIFO stage directly downstream of the APB slave decode. Consumes TX/RX/config detect strobes,

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_csr_ctrl_if.sv | 26 ++
 rtl/uart_sync_fifo.sv | 44 ++++
 rtl/uart_csr_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_csr_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART register/FIFO stage.
// DATA_WIDTH / ADDR_WIDTH normally come from the project defines; fallbacks keep the package standalone.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package uart_pkg;

   localparam int DW = `DATA_WIDTH;
   localparam int AW = `ADDR_WIDTH;

   localparam logic [AW-1:0] TRANS_DATA = AW'(8'h00);
   localparam logic [AW-1:0] RECV_DATA  = AW'(8'h04);
   localparam logic [AW-1:0] BAUD_CFG   = AW'(8'h08);
   localparam logic [AW-1:0] FRAME_CFG  = AW'(8'h0C);
   localparam logic [AW-1:0] PARITY_CFG = AW'(8'h10);
   localparam logic [AW-1:0] STOP_CFG   = AW'(8'h14);

   localparam logic [3:0] FRAME_RST  = 4'd8;
   localparam logic [1:0] PARITY_RST = 2'd0;
   localparam logic [1:0] STOP_RST   = 2'd1;

   // Legal ranges are compared against the full write word so high garbage bits are rejected.
   localparam logic [DW-1:0] FRAME_MIN  = DW'(5);
   localparam logic [DW-1:0] FRAME_MAX  = DW'(9);
   localparam logic [DW-1:0] PARITY_MAX = DW'(2);
   localparam logic [DW-1:0] STOP_MIN   = DW'(1);
   localparam logic [DW-1:0] STOP_MAX   = DW'(2);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   function automatic logic multi_hot(input logic [3:0] v);
      return |(v & (v - 4'd1));
   endfunction

endpackage

// File: rtl/uart_csr_ctrl_if.sv
// APB-side access bundle between the slave decode (master) and the register/FIFO stage (slave).
interface uart_csr_ctrl_if;
   import uart_pkg::*;

   logic          TX_detect;
   logic          RX_detect;
   logic          config_write_detect;
   logic          config_read_detect;
   logic [AW-1:0] config_address;
   logic [DW-1:0] write_data;
   logic [DW-1:0] read_data;
   logic          ready;
   logic          error;

   modport master (
      output TX_detect, RX_detect, config_write_detect, config_read_detect,
      output config_address, write_data,
      input  read_data, ready, error
   );

   modport slave (
      input  TX_detect, RX_detect, config_write_detect, config_read_detect,
      input  config_address, write_data,
      output read_data, ready, error
   );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop frees the slot for a same-cycle push when full.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk_sys,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
   end
endmodule

// File: rtl/uart_csr_ctrl.sv
// UART register/FIFO stage behind the APB decode: config registers, TX/RX FIFOs, one-wait-state response.
// Optional build macro UART_RX_OVERRUN_EN adds a sticky RX overrun flag reported on the next RX read.
//
// state | meaning
// IDLE  | waiting for a detect; side effects commit on the cycle a detect is seen here
// RESP  | ready=1, registered read_data/error presented; detects ignored
module uart_csr_ctrl
   import uart_pkg::*;
#(
   parameter int            FIFO_DEPTH   = 8,
   parameter logic [DW-1:0] BAUD_DIV_RST = DW'(54)
) (
   input  logic            PCLK,
   input  logic            PRESET,
   uart_csr_ctrl_if.slave  apb,
   output logic [7:0]      tx_data,
   output logic            tx_valid,
   input  logic            tx_ready,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   output logic [DW-1:0]   baud_cfg,
   output logic [3:0]      frame_cfg,
   output logic [1:0]      parity_cfg,
   output logic [1:0]      stop_cfg
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t        state_q, state_d;
   logic [3:0]    det;
   logic          any_det, multi_det, commit;
   logic          do_tx, do_rx;
   logic          tx_pop, tx_full, tx_empty;
   logic          rx_full, rx_empty;
   logic [7:0]    rx_head;
   logic [CW-1:0] tx_count_unused, rx_count_unused;
   logic          resp_ready;
   logic [DW-1:0] resp_data_q, resp_data_d;
   logic          resp_err_q, resp_err_d;
   logic [DW-1:0] baud_d;
   logic [3:0]    frame_d;
   logic [1:0]    parity_d, stop_d;

   assign det       = {apb.TX_detect, apb.RX_detect, apb.config_write_detect, apb.config_read_detect};
   assign any_det   = |det;
   assign multi_det = multi_hot(det);
   assign commit    = (state_q == IDLE) && any_det;
   assign do_tx     = commit && !multi_det && apb.TX_detect;
   assign do_rx     = commit && !multi_det && apb.RX_detect;
   assign tx_valid  = !tx_empty;
   assign tx_pop    = tx_valid && tx_ready;

   always_ff @(posedge PCLK) begin
      if (PRESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_det) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_sys (PCLK),
      .rst     (PRESET),
      .push    (do_tx),
      .wdata   (apb.write_data[7:0]),
      .pop     (tx_pop),
      .rdata   (tx_data),
      .full    (tx_full),
      .empty   (tx_empty),
      .count   (tx_count_unused)
   );

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_sys (PCLK),
      .rst     (PRESET),
      .push    (rx_valid),
      .wdata   (rx_data),
      .pop     (do_rx),
      .rdata   (rx_head),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (rx_count_unused)
   );

`ifdef UART_RX_OVERRUN_EN
   logic overrun_q;

   // An RX read pops, so a drop can never coincide with the clearing read.
   always_ff @(posedge PCLK) begin
      if (PRESET)                               overrun_q <= 1'b0;
      else if (rx_valid && rx_full && !do_rx)   overrun_q <= 1'b1;
      else if (do_rx)                           overrun_q <= 1'b0;
   end
`endif

   always_comb begin
      resp_data_d = '0;
      resp_err_d  = 1'b0;
      baud_d      = baud_cfg;
      frame_d     = frame_cfg;
      parity_d    = parity_cfg;
      stop_d      = stop_cfg;
      if (commit) begin
         if (multi_det) begin
            resp_err_d = 1'b1;
         end else if (apb.TX_detect) begin
            resp_err_d = tx_full && !tx_pop;
         end else if (apb.RX_detect) begin
            resp_data_d = rx_empty ? '0 : {{(DW-8){1'b0}}, rx_head};
`ifdef UART_RX_OVERRUN_EN
            resp_err_d  = rx_empty || overrun_q;
`else
            resp_err_d  = rx_empty;
`endif
         end else if (apb.config_write_detect) begin
            resp_err_d = 1'b1;
            case (apb.config_address)
               BAUD_CFG:
                  if (apb.write_data != '0) begin
                     baud_d     = apb.write_data;
                     resp_err_d = 1'b0;
                  end
               FRAME_CFG:
                  if (apb.write_data >= FRAME_MIN && apb.write_data <= FRAME_MAX) begin
                     frame_d    = apb.write_data[3:0];
                     resp_err_d = 1'b0;
                  end
               PARITY_CFG:
                  if (apb.write_data <= PARITY_MAX) begin
                     parity_d   = apb.write_data[1:0];
                     resp_err_d = 1'b0;
                  end
               STOP_CFG:
                  if (apb.write_data >= STOP_MIN && apb.write_data <= STOP_MAX) begin
                     stop_d     = apb.write_data[1:0];
                     resp_err_d = 1'b0;
                  end
               default: resp_err_d = 1'b1;
            endcase
         end else begin
            case (apb.config_address)
               BAUD_CFG:   resp_data_d = baud_cfg;
               FRAME_CFG:  resp_data_d = {{(DW-4){1'b0}}, frame_cfg};
               PARITY_CFG: resp_data_d = {{(DW-2){1'b0}}, parity_cfg};
               STOP_CFG:   resp_data_d = {{(DW-2){1'b0}}, stop_cfg};
               default:    resp_err_d  = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
         baud_cfg    <= BAUD_DIV_RST;
         frame_cfg   <= FRAME_RST;
         parity_cfg  <= PARITY_RST;
         stop_cfg    <= STOP_RST;
      end else begin
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
         baud_cfg    <= baud_d;
         frame_cfg   <= frame_d;
         parity_cfg  <= parity_d;
         stop_cfg    <= stop_d;
      end
   end

   assign resp_ready    = (state_q == RESP);
   assign apb.ready     = resp_ready;
   assign apb.read_data = resp_ready ? resp_data_q : '0;
   assign apb.error     = resp_ready && resp_err_q;
endmodule

// File: tb/tb_uart_csr_ctrl.sv
// Self-checking bench for uart_csr_ctrl: config vector table plus FIFO/reset sequences, scoreboarded responses.
module tb_uart_csr_ctrl;
   import uart_pkg::*;

   localparam int DEPTH = 8;
   localparam logic [3:0] DET_TX = 4'b1000;
   localparam logic [3:0] DET_RX = 4'b0100;
   localparam logic [3:0] DET_CW = 4'b0010;
   localparam logic [3:0] DET_CR = 4'b0001;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [DW-1:0] baud_cfg;
   logic [3:0]    frame_cfg;
   logic [1:0]    parity_cfg;
   logic [1:0]    stop_cfg;

   uart_csr_ctrl_if apb();

   uart_csr_ctrl #(.FIFO_DEPTH(DEPTH), .BAUD_DIV_RST(DW'(54))) dut (
      .PCLK       (PCLK),
      .PRESET     (PRESET),
      .apb        (apb),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .baud_cfg   (baud_cfg),
      .frame_cfg  (frame_cfg),
      .parity_cfg (parity_cfg),
      .stop_cfg   (stop_cfg)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [DW-1:0] data;
      bit            err;
      bit            chk_data;
      string         nm;
   } resp_t;

   typedef struct {
      logic [3:0]    det;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [DW-1:0] exp_data;
      bit            exp_err;
      bit            chk_data;
      logic [DW-1:0] e_baud;
      logic [3:0]    e_frame;
      logic [1:0]    e_par;
      logic [1:0]    e_stop;
      string         nm;
   } vec_t;

   resp_t      exp_q[$];
   logic [7:0] tx_m[$];
   logic [7:0] rx_m[$];
   bit         ovr_m;
   int         n_pass  = 0;
   int         n_total = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Response scoreboard: every ready pulse must match the oldest outstanding expectation.
   always @(negedge PCLK) begin
      if (apb.ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_ready: got ready=1 expected no response");
         end else begin
            resp_t e;
            e = exp_q.pop_front();
            chk({e.nm, "_err"}, DW'(apb.error), DW'(e.err));
            if (e.chk_data) chk({e.nm, "_data"}, apb.read_data, e.data);
         end
      end
   end

   task automatic set_det(input logic [3:0] d);
      apb.TX_detect           = d[3];
      apb.RX_detect           = d[2];
      apb.config_write_detect = d[1];
      apb.config_read_detect  = d[0];
   endtask

   task automatic access(input logic [3:0] d, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [DW-1:0] exp_data, input bit exp_err, input bit chk_data,
                         input bit pulse_rdy, input string nm);
      resp_t e;
      @(posedge PCLK); #1;
      set_det(d);
      apb.config_address = addr;
      apb.write_data     = wd;
      if (pulse_rdy) tx_ready = 1'b1;
      e.data = exp_data; e.err = exp_err; e.chk_data = chk_data; e.nm = nm;
      exp_q.push_back(e);
      @(negedge PCLK); #1;
      chk({nm, "_wait"}, DW'(apb.ready), DW'(0));
      @(posedge PCLK); #1;
      if (pulse_rdy) tx_ready = 1'b0;
      @(negedge PCLK); #1;
      chk({nm, "_latency"}, DW'(exp_q.size()), DW'(0));
      exp_q.delete();
      @(posedge PCLK); #1;
      set_det(4'b0000);
   endtask

   task automatic tx_write(input logic [7:0] b, input bit rdy, input string nm);
      bit full, ok;
      full = (tx_m.size() == DEPTH);
      ok   = !full || (rdy && tx_m.size() > 0);
      if (rdy && tx_m.size() > 0) void'(tx_m.pop_front());
      if (ok) tx_m.push_back(b);
      access(DET_TX, TRANS_DATA, DW'(b), '0, !ok, 1'b0, rdy, nm);
   endtask

   task automatic rx_inject(input logic [7:0] b);
      @(posedge PCLK); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge PCLK); #1;
      rx_valid = 1'b0;
      if (rx_m.size() < DEPTH) rx_m.push_back(b);
`ifdef UART_RX_OVERRUN_EN
      else ovr_m = 1'b1;
`endif
   endtask

   task automatic rx_read(input string nm);
      logic [DW-1:0] d;
      bit            e;
      if (rx_m.size() == 0) begin
         d = '0;
         e = 1'b1;
      end else begin
         d = DW'(rx_m.pop_front());
         e = 1'b0;
      end
      e     = e || ovr_m;
      ovr_m = 1'b0;
      access(DET_RX, RECV_DATA, '0, d, e, 1'b1, 1'b0, nm);
   endtask

   task automatic chk_cfg(input string nm, input logic [DW-1:0] b, input logic [3:0] f,
                          input logic [1:0] p, input logic [1:0] s);
      chk({nm, "_baud"},   baud_cfg,        b);
      chk({nm, "_frame"},  DW'(frame_cfg),  DW'(f));
      chk({nm, "_parity"}, DW'(parity_cfg), DW'(p));
      chk({nm, "_stop"},   DW'(stop_cfg),   DW'(s));
   endtask

   vec_t vecs[$];

   initial begin
      ovr_m    = 1'b0;
      PRESET   = 1'b1;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data  = '0;
      set_det(4'b0000);
      apb.config_address = '0;
      apb.write_data     = '0;

      //          det     addr        wd        exp_data err chk baud      frm par stop name
      vecs.push_back('{DET_CR, FRAME_CFG,  DW'(0),  DW'(8),  0, 1, DW'(54), 8, 0, 1, "rd_frame_rst"});
      vecs.push_back('{DET_CR, BAUD_CFG,   DW'(0),  DW'(54), 0, 1, DW'(54), 8, 0, 1, "rd_baud_rst"});
      vecs.push_back('{DET_CR, PARITY_CFG, DW'(0),  DW'(0),  0, 1, DW'(54), 8, 0, 1, "rd_parity_rst"});
      vecs.push_back('{DET_CR, STOP_CFG,   DW'(0),  DW'(1),  0, 1, DW'(54), 8, 0, 1, "rd_stop_rst"});
      vecs.push_back('{DET_CW, BAUD_CFG,   DW'(0),  DW'(0),  1, 0, DW'(54), 8, 0, 1, "wr_baud0"});
      vecs.push_back('{DET_CW, BAUD_CFG,   DW'(27), DW'(0),  0, 0, DW'(27), 8, 0, 1, "wr_baud27"});
      vecs.push_back('{DET_CW, FRAME_CFG,  DW'(4),  DW'(0),  1, 0, DW'(27), 8, 0, 1, "wr_frame4"});
      vecs.push_back('{DET_CW, FRAME_CFG,  DW'(10), DW'(0),  1, 0, DW'(27), 8, 0, 1, "wr_frame10"});
      vecs.push_back('{DET_CW, FRAME_CFG,  DW'(5),  DW'(0),  0, 0, DW'(27), 5, 0, 1, "wr_frame5"});
      vecs.push_back('{DET_CW, FRAME_CFG,  DW'(9),  DW'(0),  0, 0, DW'(27), 9, 0, 1, "wr_frame9"});
      vecs.push_back('{DET_CW, PARITY_CFG, DW'(3),  DW'(0),  1, 0, DW'(27), 9, 0, 1, "wr_parity3"});
      vecs.push_back('{DET_CW, PARITY_CFG, DW'(2),  DW'(0),  0, 0, DW'(27), 9, 2, 1, "wr_parity2"});
      vecs.push_back('{DET_CW, STOP_CFG,   DW'(0),  DW'(0),  1, 0, DW'(27), 9, 2, 1, "wr_stop0"});
      vecs.push_back('{DET_CW, STOP_CFG,   DW'(3),  DW'(0),  1, 0, DW'(27), 9, 2, 1, "wr_stop3"});
      vecs.push_back('{DET_CW, STOP_CFG,   DW'(2),  DW'(0),  0, 0, DW'(27), 9, 2, 2, "wr_stop2"});
      vecs.push_back('{DET_CR, STOP_CFG,   DW'(0),  DW'(2),  0, 1, DW'(27), 9, 2, 2, "rd_stop2"});
      vecs.push_back('{DET_CR, FRAME_CFG,  DW'(0),  DW'(9),  0, 1, DW'(27), 9, 2, 2, "rd_frame9"});
      vecs.push_back('{DET_CR, BAUD_CFG,   DW'(0),  DW'(27), 0, 1, DW'(27), 9, 2, 2, "rd_baud27"});
      vecs.push_back('{DET_RX, RECV_DATA,  DW'(0),  DW'(0),  1, 1, DW'(27), 9, 2, 2, "rd_rx_empty"});

      repeat (3) @(posedge PCLK);
      @(negedge PCLK); #1;
      chk("rst_ready",    DW'(apb.ready), DW'(0));
      chk("rst_error",    DW'(apb.error), DW'(0));
      chk("rst_rdata",    apb.read_data,  DW'(0));
      chk("rst_tx_valid", DW'(tx_valid),  DW'(0));
      chk_cfg("rst", DW'(54), 4'd8, 2'd0, 2'd1);
      @(posedge PCLK); #1;
      PRESET = 1'b0;

      foreach (vecs[i]) begin
         access(vecs[i].det, vecs[i].addr, vecs[i].wd, vecs[i].exp_data,
                vecs[i].exp_err, vecs[i].chk_data, 1'b0, vecs[i].nm);
         chk_cfg(vecs[i].nm, vecs[i].e_baud, vecs[i].e_frame, vecs[i].e_par, vecs[i].e_stop);
      end

      // Several detects at once: error, zero data, no side effect.
      access(DET_TX | DET_CR, FRAME_CFG, DW'(8'h55), '0, 1'b1, 1'b1, 1'b0, "multi_tx_cr");
      chk("multi_no_push", DW'(tx_valid), DW'(0));
      access(DET_CW | DET_CR, BAUD_CFG, DW'(5), '0, 1'b1, 1'b1, 1'b0, "multi_cw_cr");
      chk_cfg("multi_cfg", DW'(27), 4'd9, 2'd2, 2'd2);

      // TX fill with the transmitter stalled, overflow, then push+pop on a full FIFO.
      for (int i = 0; i < DEPTH; i++) tx_write(8'h11 + 8'(i), 1'b0, "tx_fill");
      chk("tx_valid_full", DW'(tx_valid), DW'(1));
      tx_write(8'h19, 1'b0, "tx_overflow");
      tx_write(8'h1A, 1'b1, "tx_full_pushpop");
      @(posedge PCLK); #1;
      tx_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge PCLK); #1;
         chk("tx_drain_valid", DW'(tx_valid), DW'(1));
         chk("tx_drain_data", DW'(tx_data), DW'(tx_m.pop_front()));
      end
      @(negedge PCLK); #1;
      chk("tx_drained", DW'(tx_valid), DW'(0));
      tx_ready = 1'b0;

      // RX single byte, then fill plus one dropped byte.
      rx_inject(8'hA5);
      rx_read("rx_a5");
      for (int i = 0; i < DEPTH; i++) rx_inject(8'h30 + 8'(i));
      rx_inject(8'hEE);
      for (int i = 0; i < DEPTH; i++) rx_read("rx_drain");
      rx_read("rx_empty_after");

      // Reset during the response cycle of a TX write.
      @(posedge PCLK); #1;
      set_det(DET_TX);
      apb.write_data = DW'(8'h77);
      begin
         resp_t e;
         e.data = '0; e.err = 1'b0; e.chk_data = 1'b0; e.nm = "rst_mid_tx";
         exp_q.push_back(e);
      end
      @(posedge PCLK); #1;
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      set_det(4'b0000);
      @(negedge PCLK); #1;
      chk("rst_mid_ready",    DW'(apb.ready), DW'(0));
      chk("rst_mid_error",    DW'(apb.error), DW'(0));
      chk("rst_mid_rdata",    apb.read_data,  DW'(0));
      chk("rst_mid_tx_valid", DW'(tx_valid),  DW'(0));
      chk("rst_mid_resp",     DW'(exp_q.size()), DW'(0));
      exp_q.delete();
      chk_cfg("rst_mid", DW'(54), 4'd8, 2'd0, 2'd1);
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      tx_m.delete();
      rx_m.delete();
      ovr_m = 1'b0;
      access(DET_CR, FRAME_CFG, '0, DW'(8), 1'b0, 1'b1, 1'b0, "post_rst_frame");
      rx_read("post_rst_rx_empty");
      repeat (3) @(posedge PCLK);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
